piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 106 ++++++++++
 tb/tb_piso_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// 4-bit parallel-in serial-out transmitter, MSB first, with registered outputs.
// Optional macro PIS_PARITY_EN appends an even-parity bit to each frame.
`timescale 1ns/1ps

module piso_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       en,
    output logic       sout,
    output logic       sout_valid,
    output logic       frame_start,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
`ifdef PIS_PARITY_EN
        StPar,
`endif
        StDone
    } state_e;

    state_e     state;
    logic [3:0] sreg;
    logic [1:0] cnt;

    // sreg rotates rather than shifts, so the captured word stays intact for parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            sreg        <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (load_valid) begin
                        state       <= StShift;
                        sreg        <= din;
                        cnt         <= 2'd0;
                        sout        <= din[3];
                        sout_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        load_ready  <= 1'b0;
                    end
                end
                StShift: begin
                    if (en) begin
                        frame_start <= 1'b0;
                        if (cnt == 2'd3) begin
`ifdef PIS_PARITY_EN
                            state <= StPar;
                            sout  <= ^sreg;
`else
                            state      <= StDone;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            done       <= 1'b1;
`endif
                        end else begin
                            cnt  <= cnt + 2'd1;
                            sreg <= {sreg[2:0], sreg[3]};
                            sout <= sreg[2];
                        end
                    end
                end
`ifdef PIS_PARITY_EN
                StPar: begin
                    if (en) begin
                        state      <= StDone;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                StDone: begin
                    state      <= StIdle;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state       <= StIdle;
                    sout        <= 1'b0;
                    sout_valid  <= 1'b0;
                    frame_start <= 1'b0;
                    busy        <= 1'b0;
                    load_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: stimulus pushes expected bits, a negedge monitor pops and checks.
// Works with and without PIS_PARITY_EN defined.
`timescale 1ns/1ps

module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = 4'b0;
    logic       load_valid = 1'b0;
    logic       en = 1'b0;
    logic       load_ready, sout, sout_valid, frame_start, busy, done;

    piso_tx dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .en          (en),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        bit val;
        bit first;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cyc = -100;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // bits is the expected serial stream MSB first; par the expected parity bit.
    task automatic push_frame(input logic [3:0] bits, input logic par, input int gap);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.is_done = 1'b0;
            e.val     = bits[3-i];
            e.first   = (i == 0);
            e.gap     = (i == 0) ? gap : -1;
            sb.push_back(e);
        end
        e.is_done = 1'b0;
        e.val     = par;
        e.first   = 1'b0;
        e.gap     = -1;
`ifdef PIS_PARITY_EN
        sb.push_back(e);
`endif
        e.is_done = 1'b1;
        e.val     = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input bit toggle_en);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (toggle_en) en = ~en;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending items expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_load_ready", load_ready, 1'b1);
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            if (done || sout_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got sout_valid=%b done=%b expected idle at %0t",
                             sout_valid, done, $time);
                end else begin
                    cur = sb[0];
                    if (cur.is_done) begin
                        chk1("done_pulse", done, 1'b1);
                        chk1("done_sout_valid", sout_valid, 1'b0);
                        chk1("done_sout", sout, 1'b0);
                        chk1("done_load_ready", load_ready, 1'b0);
                        done_cyc = cyc;
                        void'(sb.pop_front());
                    end else begin
                        chk1("sout_bit", sout, cur.val);
                        chk1("bit_done_low", done, 1'b0);
                        chk1("frame_start", frame_start, cur.first);
                        chk1("shift_busy", busy, 1'b1);
                        chk1("shift_load_ready", load_ready, 1'b0);
                        if (cur.gap >= 0) chk("frame_gap", cyc - done_cyc, cur.gap);
                        if (en) void'(sb.pop_front());
                    end
                end
            end else begin
                chk1("idle_sout_zero", sout, 1'b0);
                chk1("idle_frame_start", frame_start, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_load_ready", load_ready, 1'b1);
        chk1("rst_sout", sout, 1'b0);
        chk1("rst_sout_valid", sout_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_frame_start", frame_start, 1'b0);
        rst = 1'b1;

        // 0010 with en held high
        @(posedge clk);
        #1;
        din = 4'b0010; load_valid = 1'b1; en = 1'b1;
        push_frame(4'b0010, 1'b1, -1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk1("accept_busy", busy, 1'b1);
        chk1("accept_sout_valid", sout_valid, 1'b1);
        wait_drain(20, 1'b0);

        // 0101 with en alternating, every bit held two cycles
        din = 4'b0101; load_valid = 1'b1; en = 1'b0;
        push_frame(4'b0101, 1'b0, -1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        en = 1'b0;
        wait_drain(40, 1'b1);
        en = 1'b1;

        // Reset after two bits of 1011
        din = 4'b1011; load_valid = 1'b1;
        push_frame(4'b1011, 1'b1, -1);
        sb.delete();
        cur.is_done = 1'b0; cur.first = 1'b1; cur.val = 1'b1; cur.gap = -1;
        sb.push_back(cur);
        cur.first = 1'b0; cur.val = 1'b0;
        sb.push_back(cur);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk1("midrst_sout", sout, 1'b0);
        chk1("midrst_sout_valid", sout_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_load_ready", load_ready, 1'b1);
        chk("midrst_bits_sent", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        din = 4'b1011; load_valid = 1'b1;
        push_frame(4'b1011, 1'b1, -1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk1("postrst_accept", busy, 1'b1);
        wait_drain(20, 1'b0);

        // load_valid held, din changed mid-frame; second frame after one IDLE cycle
        din = 4'b0010; load_valid = 1'b1; en = 1'b1;
        push_frame(4'b0010, 1'b1, -1);
        push_frame(4'b0101, 1'b0, 2);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        din = 4'b0101;
        repeat (6) @(posedge clk);
        #1;
        load_valid = 1'b0;
        wait_drain(40, 1'b0);

        // load_valid pulse with 1111 during SHIFT must be ignored
        din = 4'b0110; load_valid = 1'b1;
        push_frame(4'b0110, 1'b0, -1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        din = 4'b1111; load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0; din = 4'b0000;
        wait_drain(20, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
